// File: rtl/pmem_arbiter.sv
// Arbiter between the I-cache and D-cache for the single physical-memory port.
// A grant lasts one full pmem transaction. Defining ARB_RR_EN enables round-robin
// arbitration on contention. The default build gives the D-cache fixed priority.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  output logic              arb_sel,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   req_i, req_d;
  logic   grant_d;
  logic   serve_i, serve_d;

  assign req_i = i_pmem_read | i_pmem_write;
  assign req_d = d_pmem_read | d_pmem_write;

`ifdef ARB_RR_EN
  // last_served_q: 1 = D-cache completed the most recent transaction.
  logic last_served_q, last_served_d;

  assign grant_d = req_d & (~req_i | ~last_served_q);
`else
  assign grant_d = req_d;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifdef ARB_RR_EN
    last_served_d = last_served_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          sel_d   = 1'b1;
        end else if (req_i) begin
          state_d = SERVE_I;
          sel_d   = 1'b0;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d = RELEASE;
`ifdef ARB_RR_EN
          last_served_d = 1'b0;
`endif
        end else if (!req_i) begin
          state_d = RELEASE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d = RELEASE;
`ifdef ARB_RR_EN
          last_served_d = 1'b1;
`endif
        end else if (!req_d) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_served_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef ARB_RR_EN
      last_served_q <= last_served_d;
`endif
    end
  end

  assign serve_i = (state_q == SERVE_I);
  assign serve_d = (state_q == SERVE_D);

  // Port routing: the granted side is mirrored, everything is zero outside SERVE states.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (serve_d) begin
      pmem_read    = d_pmem_read;
      pmem_write   = d_pmem_write;
      pmem_address = d_pmem_address;
      pmem_wdata   = d_pmem_wdata;
    end else if (serve_i) begin
      pmem_read    = i_pmem_read;
      pmem_write   = i_pmem_write;
      pmem_address = i_pmem_address;
      pmem_wdata   = i_pmem_wdata;
    end
  end

  assign i_pmem_resp = serve_i & pmem_resp;
  assign d_pmem_resp = serve_d & pmem_resp;
  assign arb_busy    = serve_i | serve_d;
  assign arb_sel     = sel_q;

  a_sel_d : assert property (@(posedge clk) disable iff (rst) serve_d |-> sel_q);
  a_sel_i : assert property (@(posedge clk) disable iff (rst) serve_i |-> !sel_q);
  a_one_resp : assert property (@(posedge clk) disable iff (rst) !(i_pmem_resp && d_pmem_resp));

endmodule
